// File: rtl/seg7_pkg.sv
// seg7_pkg: segment type, blank pattern and hex-to-abcdefg table shared by the scan driver
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_OFF = 7'b0;
  localparam seg_t SEG_HEX [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to {a,b,c,d,e,f,g}, active-high
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver with frame-aligned updates, LZB and blink
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic SL = SEG_ACTIVE_LOW != 0;
  localparam logic DL = DIG_ACTIVE_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] ONE = 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic phase, pend_v, tick, wrap, acc, blank, blink_last;
  logic [4*NUM_DIGITS-1:0] act_d, pend_d;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp, lz;
  logic [3:0] nib;
  seg_t dec;
  assign tick = cnt == CW'(PRESCALE - 1);
  assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
  assign blink_last = bcnt == BW'(BLINK_FRAMES - 1);
  assign wr_ready = !pend_v;
  assign acc = wr_valid && !pend_v;
  assign nib = act_d[4*idx +: 4];
  // lz[i]: nibbles i..top are all zero
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = act_d[4*NUM_DIGITS-1 -: 4] == 4'd0;
    for (int i = NUM_DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && act_d[4*i +: 4] == 4'd0;
  end
  assign blank = (idx != '0 && lzb_en && lz[idx]) || (blink_mask[idx] && phase);
  seg7_hex_decode u_dec (.nib(nib), .seg(dec));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      bcnt <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) bcnt <= blink_last ? '0 : bcnt + 1'b1;
      if (wrap && blink_last) phase <= !phase;
    end
  // pending data only moves to active on a wrap, so a frame never mixes old and new data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_d <= '0;
      act_dp <= '0;
      pend_d <= '0;
      pend_dp <= '0;
      pend_v <= 1'b0;
    end else if (wrap && pend_v) begin
      act_d <= pend_d;
      act_dp <= pend_dp;
      pend_v <= 1'b0;
    end else if (acc) begin
      pend_d <= wr_data;
      pend_dp <= wr_dp;
      pend_v <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg <= {7{SL}};
      dp <= SL;
      dig_sel <= {NUM_DIGITS{DL}};
      frame_done <= 1'b0;
    end else begin
      seg <= (blank ? SEG_OFF : dec) ^ {7{SL}};
      dp <= (!blank && act_dp[idx]) ^ SL;
      dig_sel <= (int'(cnt) < BLANK_CYCLES ? '0 : ONE << idx) ^ {NUM_DIGITS{DL}};
      frame_done <= wrap;
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized frame-level scoreboard bench for the scan driver
module tb_seg7_scan_driver;
  logic clk = 0, rst_n = 0, wr_valid = 0, lzb_en = 0;
  logic [15:0] wr_data = 0;
  logic [3:0] wr_dp = 0, blink_mask = 0;
  logic wr_ready, dp, frame_done;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  always #5 clk = ~clk;
  seg7_scan_driver #(
    .NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .lzb_en(lzb_en), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_done(frame_done)
  );
  logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int tests = 0, fails = 0, wraps = 0;
  logic [31:0] sbq[$];
  logic mon_on = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // a whole frame as {dp,seg} per digit, digit i in bits [8i+:8]
  function automatic logic [31:0] exp_frame(input logic [15:0] d, input logic [3:0] dpv,
                                            input logic lz, input logic [3:0] bm, input int nw);
    logic [31:0] r;
    logic ph, blank;
    ph = ((nw / 2) % 2) == 1;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      blank = (i > 0 && lz && (d >> (4 * i)) == 0) || (bm[i] && ph);
      r[8*i +: 8] = blank ? 8'h00 : {dpv[i], hex_tab[d[4*i +: 4]]};
    end
    return r;
  endfunction
  initial begin : monitor
    logic synced;
    int pos;
    logic [31:0] obs;
    logic [3:0] seen;
    synced = 0; pos = 0; obs = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (!mon_on) synced = 0;
      else if (!synced) begin
        if (frame_done) begin
          synced = 1; pos = 0; obs = 0; seen = 0;
        end
      end else begin
        chk("dig_sel", 32'(dig_sel), (pos % 4 == 0) ? 0 : 32'(1 << (pos / 4)));
        chk("frame_done", 32'(frame_done), 32'(pos == 15));
        for (int d = 0; d < 4; d++)
          if (dig_sel[d]) begin
            if (seen[d]) chk("slot_stable", 32'(obs[8*d +: 8]), 32'({dp, seg}));
            obs[8*d +: 8] = {dp, seg};
            seen[d] = 1;
          end
        if (pos == 15) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL frame: got %h expected <none queued>", obs);
          end else chk("frame", obs, sbq.pop_front());
          pos = 0; obs = 0; seen = 0;
        end else pos++;
      end
    end
  end
  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      tests++; fails++;
      $display("FAIL wait_frame: got no frame_done expected within 40 cycles");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "frame_done timeout");
    end
    wraps++;
  endtask
  initial begin : driver
    logic [15:0] m_act, m_pend, d;
    logic [3:0] m_adp, m_pdp, dpv, bm;
    logic m_pv, m_late, do_w, lz;
    int o, n;
    m_act = 0; m_pend = 0; m_adp = 0; m_pdp = 0; m_pv = 0; m_late = 0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_dp", 32'(dp), 0);
    chk("rst_dig_sel", 32'(dig_sel), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst_n = 1;
    mon_on = 1;
    @(negedge clk);
    wait_frame();
    for (int f = 0; f < 44; f++) begin
      if (m_pv) begin
        m_act = m_pend; m_adp = m_pdp; m_pv = 0;
      end
      if (m_late) begin
        m_pv = 1; m_late = 0;
      end
      do_w = 1'($urandom_range(0, 1)); o = $urandom_range(0, 15);
      d = 16'($urandom); dpv = 4'($urandom); lz = 1'($urandom);
      bm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      case (f)
        0: begin do_w = 1; o = 3; d = 16'h1234; dpv = 4'b0010; lz = 0; bm = 0; end
        1, 4: begin do_w = 0; lz = 0; bm = 0; end
        2: begin do_w = 1; o = 7; d = 16'h00A0; dpv = 0; lz = 0; bm = 0; end
        3, 6: begin do_w = 0; lz = 1; bm = 0; end
        5: begin do_w = 1; o = 15; d = 16'h000F; dpv = 0; lz = 1; bm = 0; end
        7, 8, 9, 10, 11: begin do_w = 0; lz = 1; bm = 4'b0001; end
        default: ;
      endcase
      lzb_en = lz;
      blink_mask = bm;
      sbq.push_back(exp_frame(m_act, m_adp, lz, bm, wraps));
      chk("wr_ready", 32'(wr_ready), 32'(!m_pv));
      repeat (o) @(negedge clk);
      wr_valid = do_w; wr_data = d; wr_dp = dpv;
      if (do_w && !m_pv) begin
        m_pend = d; m_pdp = dpv;
        if (o == 15) m_late = 1;
        else m_pv = 1;
      end
      @(negedge clk);
      wr_valid = 0;
      wait_frame();
    end
    @(negedge clk);
    mon_on = 0;
    chk("sb_empty", 32'(sbq.size()), 0);
    lzb_en = 0;
    blink_mask = 0;
    n = 0;
    while (!wr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 1; wr_data = 16'h5555; wr_dp = 4'hF;
    @(negedge clk);
    wr_valid = 0;
    chk("pend_set", 32'(wr_ready), 0);
    n = 0;
    while ((dig_sel == 0 || seg == 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 0;
    #1;
    chk("async_seg", 32'(seg), 0);
    chk("async_dp", 32'(dp), 0);
    chk("async_dig_sel", 32'(dig_sel), 0);
    chk("async_frame_done", 32'(frame_done), 0);
    chk("async_wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    rst_n = 1;
    chk("post_rst_ready", 32'(wr_ready), 1);
    repeat (40) begin
      @(negedge clk);
      if (dig_sel != 0) chk("post_rst_digit", 32'({dp, seg}), 32'h7E);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
